// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } ctrl_state_t;

   // Architectural zero register; writes to it are discarded, so it never hazards.
   localparam logic [4:0] XZR = 5'd31;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_bubble;
      logic exmem_en;
      logic memwb_bubble;
   } pipe_ctl_t;

   // Canned pipe-register control patterns, field order as in pipe_ctl_t.
   localparam pipe_ctl_t CTL_RUN        = pipe_ctl_t'(7'b1101010);
   localparam pipe_ctl_t CTL_BRANCH     = pipe_ctl_t'(7'b1111010);
   localparam pipe_ctl_t CTL_LUH_STALL  = pipe_ctl_t'(7'b0001110);
   localparam pipe_ctl_t CTL_MEM_FREEZE = pipe_ctl_t'(7'b0000001);
   localparam pipe_ctl_t CTL_HALT       = pipe_ctl_t'(7'b0000101);

endpackage

// File: rtl/pipe_hazard_ctrl_luh.sv
// Load-use hazard detector: an EX-stage load feeding a register the ID
// instruction reads cannot be forwarded in time and needs one bubble.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] ID_Rn,
   input  logic [4:0] ID_Rm,
   input  logic       ID_usesRn,
   input  logic       ID_usesRm,
   input  logic [4:0] EX_Rd,
   input  logic       EX_read_enable,
   input  logic       EX_RegWrite,
   output logic       luh
);

   // Hazard when the loaded register matches any source actually read in ID.
   always_comb begin
      luh = EX_read_enable & EX_RegWrite & (EX_Rd != XZR) &
            ((ID_usesRn & (ID_Rn == EX_Rd)) | (ID_usesRm & (ID_Rm == EX_Rd)));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RUN      | normal flow; load-use stall and branch squash handled here
//   MEM_WAIT | data memory busy, whole pipe frozen, watchdog counting
//   ERROR    | memory never answered; pipe frozen until reset
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TMO_W       = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_Rn,
   input  logic [4:0]       ID_Rm,
   input  logic             ID_usesRn,
   input  logic             ID_usesRm,
   input  logic             ID_BrTaken,
   input  logic [4:0]       EX_Rd,
   input  logic             EX_read_enable,
   input  logic             EX_RegWrite,
   input  logic             MEM_req,
   input  logic             MEM_ack,
   output logic             PC_en,
   output logic             IFID_en,
   output logic             IFID_flush,
   output logic             IDEX_en,
   output logic             IDEX_bubble,
   output logic             EXMEM_en,
   output logic             MEMWB_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [TMO_W:0] TMO_LIM = (TMO_W+1)'(MEM_TIMEOUT);

   ctrl_state_t      state_q, state_d;
   logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [TMO_W:0]   wait_nxt;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             luh;
   logic             mem_busy;
   logic             mem_done;
   pipe_ctl_t        run_ctl;
   pipe_ctl_t        ctl;
   pipe_ctl_t        ctl_out;

   load_use_detect u_luh (
      .ID_Rn          (ID_Rn),
      .ID_Rm          (ID_Rm),
      .ID_usesRn      (ID_usesRn),
      .ID_usesRm      (ID_usesRm),
      .EX_Rd          (EX_Rd),
      .EX_read_enable (EX_read_enable),
      .EX_RegWrite    (EX_RegWrite),
      .luh            (luh)
   );

   // Next state, watchdog and Mealy pipe controls; luh outranks the branch so
   // the branch is re-resolved with forwarded data after the bubble.
   always_comb begin
      mem_busy   = MEM_req & ~MEM_ack;
      mem_done   = MEM_req & MEM_ack;
      run_ctl    = luh ? CTL_LUH_STALL : (ID_BrTaken ? CTL_BRANCH : CTL_RUN);
      ctl        = run_ctl;
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      wait_nxt   = {1'b0, wait_cnt_q} + 1'b1;
      unique case (state_q)
         RUN: begin
            if (mem_busy) begin
               ctl        = CTL_MEM_FREEZE;
               state_d    = MEM_WAIT;
               wait_cnt_d = TMO_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_done) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else begin
               ctl        = CTL_MEM_FREEZE;
               wait_cnt_d = wait_nxt[TMO_W-1:0];
               if (wait_nxt >= TMO_LIM) state_d = ERROR;
            end
         end
         ERROR: begin
            ctl = CTL_HALT;
         end
         default: begin
            ctl     = CTL_HALT;
            state_d = ERROR;
         end
      endcase
      mem_timeout_d = mem_timeout_q | (state_d == ERROR);
      stall_count_d = stall_count_q;
      if (!ctl.pc_en && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Hold the pipe with NOOPs injected while reset is asserted.
   always_comb begin
      ctl_out      = reset ? ctl : CTL_HALT;
      PC_en        = ctl_out.pc_en;
      IFID_en      = ctl_out.ifid_en;
      IFID_flush   = ctl_out.ifid_flush;
      IDEX_en      = ctl_out.idex_en;
      IDEX_bubble  = ctl_out.idex_bubble;
      EXMEM_en     = ctl_out.exmem_en;
      MEMWB_bubble = ctl_out.memwb_bubble;
      mem_timeout  = mem_timeout_q;
      stall_count  = stall_count_q;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a rule-level model.
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ID_Rn, ID_Rm, EX_Rd;
   logic        ID_usesRn, ID_usesRm, ID_BrTaken;
   logic        EX_read_enable, EX_RegWrite, MEM_req, MEM_ack;
   logic        PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_bubble;
   logic        mem_timeout;
   logic [15:0] stall_count;
   logic        s_pc, s_ifid, s_fl, s_idex, s_idb, s_exm, s_mwb, s_mt;
   logic [3:0]  stall_count4;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   bit m_waiting, m_err;
   int m_busy_run;
   int m_cnt16, m_cnt4;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_usesRn(ID_usesRn),
      .ID_usesRm(ID_usesRm), .ID_BrTaken(ID_BrTaken), .EX_Rd(EX_Rd),
      .EX_read_enable(EX_read_enable), .EX_RegWrite(EX_RegWrite), .MEM_req(MEM_req),
      .MEM_ack(MEM_ack), .PC_en(PC_en), .IFID_en(IFID_en), .IFID_flush(IFID_flush),
      .IDEX_en(IDEX_en), .IDEX_bubble(IDEX_bubble), .EXMEM_en(EXMEM_en),
      .MEMWB_bubble(MEMWB_bubble), .mem_timeout(mem_timeout), .stall_count(stall_count)
   );

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(4), .CNT_W(4)) dut_c4 (
      .clk(clk), .reset(reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_usesRn(ID_usesRn),
      .ID_usesRm(ID_usesRm), .ID_BrTaken(ID_BrTaken), .EX_Rd(EX_Rd),
      .EX_read_enable(EX_read_enable), .EX_RegWrite(EX_RegWrite), .MEM_req(MEM_req),
      .MEM_ack(MEM_ack), .PC_en(s_pc), .IFID_en(s_ifid), .IFID_flush(s_fl),
      .IDEX_en(s_idex), .IDEX_bubble(s_idb), .EXMEM_en(s_exm),
      .MEMWB_bubble(s_mwb), .mem_timeout(s_mt), .stall_count(stall_count4)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_luh();
      if (!(EX_read_enable && EX_RegWrite) || EX_Rd == 5'd31) return 1'b0;
      return (ID_usesRn && ID_Rn == EX_Rd) || (ID_usesRm && ID_Rm == EX_Rd);
   endfunction

   // Expected {PC_en,IFID_en,IFID_flush,IDEX_en,IDEX_bubble,EXMEM_en,MEMWB_bubble}
   function automatic logic [6:0] model_ctl();
      bit frozen;
      if (!reset || m_err) return 7'b0000101;
      frozen = m_waiting ? !(MEM_req && MEM_ack) : (MEM_req && !MEM_ack);
      if (frozen)     return 7'b0000001;
      if (model_luh()) return 7'b0001110;
      if (ID_BrTaken) return 7'b1111010;
      return 7'b1101010;
   endfunction

   task automatic model_reset();
      m_waiting = 0; m_err = 0; m_busy_run = 0; m_cnt16 = 0; m_cnt4 = 0;
   endtask

   task automatic drive(input logic [4:0] rn, input logic [4:0] rm, input bit urn, input bit urm,
                        input bit br, input logic [4:0] rd, input bit ld, input bit rw,
                        input bit req, input bit ack);
      ID_Rn = rn; ID_Rm = rm; ID_usesRn = urn; ID_usesRm = urm; ID_BrTaken = br;
      EX_Rd = rd; EX_read_enable = ld; EX_RegWrite = rw; MEM_req = req; MEM_ack = ack;
   endtask

   // Called just after a falling edge with inputs set; checks before the rising
   // edge, advances the model across it, and returns at the next falling edge.
   task automatic cycle(input string tag);
      logic [6:0] exp;
      #4;
      exp = model_ctl();
      check_val({tag, "_ctl"}, {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_bubble}, 32'(exp));
      check_val({tag, "_cnt"}, 32'(stall_count), 32'(m_cnt16));
      check_val({tag, "_cnt4"}, 32'(stall_count4), 32'(m_cnt4));
      check_val({tag, "_tmo"}, 32'(mem_timeout), 32'(m_err));
      if (reset) begin
         if (!exp[6]) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         if (!m_err) begin
            if (m_waiting) begin
               if (MEM_req && MEM_ack) begin
                  m_waiting = 0; m_busy_run = 0;
               end else begin
                  m_busy_run++;
                  if (m_busy_run >= MEM_TIMEOUT) m_err = 1;
               end
            end else if (MEM_req && !MEM_ack) begin
               m_waiting = 1; m_busy_run = 1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drive_random();
      logic [4:0] pick[4];
      pick[0] = 5'd1; pick[1] = 5'd2; pick[2] = 5'd3; pick[3] = 5'd31;
      drive(pick[$urandom_range(3)], pick[$urandom_range(3)], 1'($urandom), 1'($urandom),
            ($urandom_range(3) == 0), pick[$urandom_range(3)], 1'($urandom), 1'($urandom),
            ($urandom_range(3) == 0), 1'($urandom));
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      // reset held three cycles
      repeat (3) cycle("rst");
      reset = 1'b1;
      cycle("idle");

      // load-use on Rn, then the load has moved on
      drive(5, 0, 1, 0, 0, 5, 1, 1, 0, 0);
      cycle("luh_rn");
      drive(5, 0, 1, 0, 0, 7, 0, 0, 0, 0);
      cycle("luh_after");
      // XZR never hazards
      drive(31, 31, 1, 1, 0, 31, 1, 1, 0, 0);
      cycle("luh_xzr");
      // hazard through Rm only
      drive(1, 9, 0, 1, 0, 9, 1, 1, 0, 0);
      cycle("luh_rm");

      // branch with simultaneous hazard: stall first, flush next cycle
      drive(5, 0, 1, 0, 1, 5, 1, 1, 0, 0);
      cycle("br_luh");
      drive(5, 0, 1, 0, 1, 7, 0, 0, 0, 0);
      cycle("br_flush");

      // memory busy 4 cycles then ack
      repeat (4) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         cycle("mem_wait");
      end
      drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
      cycle("mem_ack");
      // ack with no request is ignored
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle("ack_noreq");

      // long hazard hold saturates the 4-bit counter
      repeat (20) begin
         drive(4, 0, 1, 0, 0, 4, 1, 1, 0, 0);
         cycle("sat");
      end

      // randomized traffic
      repeat (400) begin
         drive_random();
         cycle("rand");
      end

      // async reset mid memory wait
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle("pre_rst_wait");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_val("async_rst_ctl", {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_bubble}, 32'h05);
      check_val("async_rst_cnt", 32'(stall_count), 32'd0);
      @(negedge clk);
      cycle("rst_hold");
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("post_rst");

      // watchdog: ack never arrives
      repeat (MEM_TIMEOUT) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         cycle("tmo_wait");
      end
      repeat (3) begin
         drive(2, 2, 1, 1, 1, 3, 0, 0, 1, 1);
         cycle("err_hold");
      end
      check_val("err_sticky", 32'(mem_timeout), 32'd1);

      reset = 1'b0;
      #1;
      model_reset();
      check_val("err_rst_tmo", 32'(mem_timeout), 32'd0);
      check_val("err_rst_cnt", 32'(stall_count), 32'd0);
      @(negedge clk);
      cycle("err_rst_hold");
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) cycle("recover");

      // more randomized traffic after recovery
      repeat (200) begin
         drive_random();
         cycle("rand2");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined ARM datapath.
- Drives the enable and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers.
- Detects load-use hazards and squashes the wrong-path fetch on branches resolved in ID.
- Freezes the whole pipe while data memory is busy, with a timeout watchdog and a stall-cycle counter.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before entering ERROR (1..2^TMO_W-1)
TMO_W, 4, width of wait-cycle counter
CNT_W, 16, width of stall_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; asserted when 0
ID_Rn  in  5  Rn field of instruction in ID
ID_Rm  in  5  second source register in ID (already Reg2Loc-muxed)
ID_usesRn  in  1  ID instruction reads Rn
ID_usesRm  in  1  ID instruction reads second source
ID_BrTaken  in  1  branch in ID resolved taken
EX_Rd  in  5  destination of instruction in EX
EX_read_enable  in  1  EX instruction is a load
EX_RegWrite  in  1  EX instruction writes regfile
MEM_req  in  1  MEM-stage instruction accesses data memory
MEM_ack  in  1  data memory completes access this cycle
PC_en  out  1  PC update enable
IFID_en  out  1  IF/ID load enable
IFID_flush  out  1  IF/ID loads NOOP
IDEX_en  out  1  ID/EX load enable
IDEX_bubble  out  1  ID/EX loads NOOP (all control bits zero)
EXMEM_en  out  1  EX/MEM load enable
MEMWB_bubble  out  1  MEM/WB loads NOOP
mem_timeout  out  1  sticky error flag
stall_count  out  CNT_W  saturating count of cycles with PC_en=0

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Registered state; outputs are Mealy (state + current inputs), zero latency.
- Reset (reset==0, async):
  - state=RUN, wait counter=0, stall_count=0, mem_timeout=0.
  - While reset is held, outputs are forced: all *_en=0, IFID_flush=0, IDEX_bubble=1, MEMWB_bubble=1.
- Load-use hazard, luh = EX_read_enable & EX_RegWrite & EX_Rd!=31 & ((ID_usesRn & ID_Rn==EX_Rd) | (ID_usesRm & ID_Rm==EX_Rd)).
  - X31 is XZR and never hazards.
- mem_busy = MEM_req & !MEM_ack.
- Priority: ERROR > mem_busy > luh > ID_BrTaken.
- RUN, default: all en=1, flush=0, bubbles=0.
- RUN, mem_busy:
  - Outputs: all en=0, MEMWB_bubble=1, IFID_flush=0, IDEX_bubble=0.
  - Next state MEM_WAIT; wait counter := 1.
- RUN, luh and not mem_busy:
  - Outputs: PC_en=0, IFID_en=0, IDEX_en=1, IDEX_bubble=1, EXMEM_en=1, IFID_flush=0.
  - Exactly one bubble per hazard, since the load advances to MEM.
- RUN, ID_BrTaken and neither of the above: IFID_flush=1, all en=1.
- Simultaneous luh and ID_BrTaken: stall only. The branch is re-evaluated next cycle with forwarded data, so the flush happens one cycle later.
- MEM_WAIT, MEM_ack=1:
  - Outputs are identical to RUN evaluated on the same inputs (luh/branch honoured).
  - Next state RUN; wait counter := 0.
- MEM_WAIT, MEM_ack=0:
  - Full freeze as above; wait counter increments.
  - When counter==MEM_TIMEOUT, next state is ERROR.
- ERROR:
  - Full freeze: all en=0, IDEX_bubble=1, MEMWB_bubble=1.
  - mem_timeout=1 (registered, set on entry).
  - Only reset exits ERROR.
- MEM_ack while MEM_req=0 is ignored.
- stall_count increments on each clock edge where PC_en==0 and reset is deasserted.
  - Saturates at 2^CNT_W-1; never wraps.
  - Not cleared except by reset.
- Reset asserted mid-MEM_WAIT: returns immediately (async) to RUN with counters cleared.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum ctrl_state_t {RUN, MEM_WAIT, ERROR}
  - constant XZR = 5'd31
  - struct pipe_ctl_t bundling the seven enable/flush/bubble outputs
- Sub-module load_use_detect (combinational): ID_Rn, ID_Rm, use flags, EX_Rd, EX_read_enable, EX_RegWrite -> luh.

Test Plan:
1. Reset low 3 cycles, release, no hazards → all en=1, bubbles=0, stall_count=0, mem_timeout=0.
2. EX load X5 (EX_read_enable=1, EX_RegWrite=1, EX_Rd=5), ID_Rn=5, ID_usesRn=1 → one cycle of PC_en=0, IFID_en=0, IDEX_bubble=1; stall_count=1. Repeat with EX_Rd=31 → no stall.
3. ID_BrTaken=1 with luh active in the same cycle → cycle 1 stall, no flush; cycle 2 (luh gone, BrTaken still 1) IFID_flush=1, all en=1.
4. MEM_req=1, MEM_ack low for 4 cycles then high → 4 frozen cycles with MEMWB_bubble=1, state MEM_WAIT; on the ack cycle all en=1; stall_count=4.
5. MEM_req=1, MEM_ack held 0 for MEM_TIMEOUT=15 cycles → ERROR entered, mem_timeout=1, permanent freeze; later MEM_ack=1 has no effect. reset=0 → RUN, mem_timeout=0, stall_count=0.
6. CNT_W=4, hold luh for 20 cycles → stall_count saturates at 15.
